// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer around the adder_1bit cell, LSB first, start/done handshake.
// Optional macro SERIAL_ADD_OVF_EN adds a two's-complement overflow output (ovf).

module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             bit_s;
    logic             bit_cout;

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    adder_1bit u_add (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (bit_s),
        .cout (bit_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            busy <= (state_nxt == ST_SHIFT);
            done <= (state_nxt == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    sum   <= {bit_s, sum[WIDTH-1:1]};
                    carry <= bit_cout;
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    // Counter holds at WIDTH-1 instead of wrapping
                    if (last_bit) begin
                        cout <= bit_cout;
`ifdef SERIAL_ADD_OVF_EN
                        ovf  <= carry ^ bit_cout;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed, table-driven bench for serial_adder_ctrl (WIDTH=8); ovf checks follow SERIAL_ADD_OVF_EN.

module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full operation; called on a negedge, returns on a negedge with the block idle
    task automatic run_op(input vec_t v, input logic [W-1:0] prev_sum, input logic prev_cout);
        int busy_cnt;
        int done_at;
        int done_cnt;
        busy_cnt = 0;
        done_at  = 0;
        done_cnt = 0;
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = ~v.a; b = ~v.b; cin = ~v.cin;
        check("sum_hold_before_shift", 32'(sum), 32'(prev_sum));
        check("cout_hold_before_shift", 32'(cout), 32'(prev_cout));
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
        end
        check("busy_cycles", 32'(busy_cnt), 32'(W));
        check("done_cycle", 32'(done_at), 32'(W + 1));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("sum", 32'(sum), 32'(v.sum));
        check("cout", 32'(cout), 32'(v.cout));
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", 32'(ovf), 32'(v.ovf));
`endif
    endtask

    initial begin
        vec_t vecs[8];
        logic [W-1:0] psum;
        logic         pcout;
        int           done_at;
        int           done_cnt;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_sum", 32'(sum), 32'd0);
            check("rst_cout", 32'(cout), 32'd0);
        end

        psum = '0; pcout = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], psum, pcout);
            psum = vecs[i].sum; pcout = vecs[i].cout;
        end

        // start held high; operand change after acceptance must not matter
        @(negedge clk);
        a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'hF0;
        done_at = 0;
        for (int i = 1; i <= 22; i++) begin
            if (i > 1) @(negedge clk);
            if (done && done_at == 0) begin
                done_at = i;
                check("held_start_sum", 32'(sum), 32'h07);
                check("held_start_cout", 32'(cout), 32'd0);
            end
            if (i == 10) check("held_start_idle_gap", 32'(busy), 32'd0);
            if (i == 11) begin
                check("held_start_restart", 32'(busy), 32'd1);
                start = 1'b0;
            end
        end
        check("held_start_done_cycle", 32'(done_at), 32'd9);
        check("second_run_sum", 32'(sum), 32'hF4);
        check("second_run_cout", 32'(cout), 32'd0);

        // reset mid-SHIFT at cnt=4 discards the partial result
        @(negedge clk);
        a = 8'hFF; b = 8'h01; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("mid_rst_no_done", 32'(done_cnt), 32'd0);
        run_op(vecs[2], 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
